stopwatch_bcd: RTL and testbench
================================

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 The block SHALL have parameter WRAP, default 1: 1 = wrap at 59:59.9, 0 = saturate at 59:59.9.
REQ-002 The block SHALL have port clkin, input, 1 bit: single system clock (CLOCK_50); all state is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tick, input, 1 bit: synchronous one-cycle pulse every 100 ms, the count event.
REQ-005 The block SHALL have port key_start_n, input, 1 bit: asynchronous active-low push-button; a press toggles run/pause.
REQ-006 The block SHALL have port key_clear_n, input, 1 bit: asynchronous active-low push-button; a press clears the count.
REQ-007 The block SHALL have port key_lap_n, input, 1 bit: asynchronous active-low push-button; a press toggles lap freeze.
REQ-008 The block SHALL have output ports tenths, sec_ones, sec_tens, min_ones and min_tens, 4 bits each: displayed BCD digits MM:SS.t.
REQ-009 The block SHALL have port running, output, 1 bit: high while state is RUN.
REQ-010 The block SHALL have port lap_hold, output, 1 bit: high while the displayed digits are frozen.
REQ-011 The block SHALL have port overflow, output, 1 bit: wrap pulse (WRAP=1) or sticky saturation flag (WRAP=0).

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer (flops reset to 1); a press event is a 1-to-0 transition of the synchronized signal, one cycle wide.
REQ-013 A key sampled low at edge N SHALL take effect on state and outputs at edge N+2; holding a key SHALL generate exactly one event.
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE; start event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-015 A clear event in IDLE or PAUSE SHALL go to IDLE with all digits 0, lap_hold 0 and overflow 0; a clear event in RUN SHALL be ignored.
REQ-016 A start event and a clear event in the same cycle SHALL resolve as: in RUN, start wins (go to PAUSE); otherwise clear wins (go to IDLE).
REQ-017 A tick SHALL be counted only when the current state is RUN, including the cycle of a RUN->PAUSE transition; a tick in the cycle of an IDLE/PAUSE->RUN transition SHALL NOT be counted.
REQ-018 A counted tick SHALL update the internal digits at the next clkin edge (1-cycle latency).
REQ-019 Digit ranges SHALL be tenths 0-9, sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5, each carrying into the next digit; non-BCD values SHALL never appear.
REQ-020 With WRAP=1, a tick at 59:59.9 SHALL produce 00:00.0 and a one-cycle overflow pulse.
REQ-021 With WRAP=0, a tick at 59:59.9 SHALL hold 59:59.9 and set overflow, which stays high until a clear or reset.
REQ-022 When lap_hold=0, the output digits SHALL equal the internal digits on the same cycle.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, all digits 0, running 0, lap_hold 0, overflow 0, synchronizer flops 1.
REQ-024 Reset asserted mid-count SHALL discard the count and any pending key event; after release the block SHALL remain in IDLE until a new start event.

Configuration
REQ-025 With macro STOPWATCH_LAP_EN defined, a lap event in RUN SHALL toggle lap_hold; while lap_hold=1 the outputs SHALL show the snapshot taken at the freeze and the internal count SHALL continue.
REQ-026 With STOPWATCH_LAP_EN defined, a lap event in PAUSE SHALL release lap_hold, a lap event in IDLE SHALL be ignored, and a clear SHALL release lap_hold.
REQ-027 With STOPWATCH_LAP_EN undefined, the lap key SHALL be ignored, lap_hold SHALL be tied 0, no snapshot registers SHALL exist, and the outputs SHALL always be live.

Verification
REQ-028 The bench SHALL cover: reset, start press, 25 ticks -> digits 00:02.5, running=1.
REQ-029 The bench SHALL cover: start press, 10 ticks, start press, 5 ticks, start press, 3 ticks -> 00:01.3, with running low during the pause.
REQ-030 The bench SHALL cover: preload to 59:59.9 via 35999 ticks, one more tick -> WRAP=1: 00:00.0 with a 1-cycle overflow pulse; WRAP=0: holds 59:59.9 with overflow sticky until clear.
REQ-031 The bench SHALL cover: in RUN, start and clear pressed in the same cycle -> PAUSE with the count retained; then clear alone -> IDLE, 00:00.0.
REQ-032 The bench SHALL cover (STOPWATCH_LAP_EN): at 00:04.0 press lap, 20 ticks -> outputs 00:04.0, lap_hold=1; press lap -> outputs 00:06.0.
REQ-033 The bench SHALL cover: rst_n low at 00:07.3 while running and lap frozen -> all outputs 0 asynchronously, and ticks after release are not counted until a start event.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS.t BCD stopwatch with run/pause/clear keys.
// Keys are asynchronous active-low buttons, each synchronized and edge-detected so
// that a held key produces a single event. Counting advances on the 100 ms tick
// while in RUN.
// Optional lap-freeze display is enabled with the macro STOPWATCH_LAP_EN. Without it,
// the lap key is ignored and the outputs are always live.
`timescale 1ns/1ps
module stopwatch_bcd #(
  parameter int unsigned WRAP = 1
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       key_lap_n,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  start_sync_q, clear_sync_q;
  logic        start_ev, clear_ev;
  logic        do_clear, count_en, at_max;
  logic [3:0]  tenths_q, tenths_d;
  logic [3:0]  sec_ones_q, sec_ones_d;
  logic [3:0]  sec_tens_q, sec_tens_d;
  logic [3:0]  min_ones_q, min_ones_d;
  logic [3:0]  min_tens_q, min_tens_d;
  logic        overflow_q, overflow_d;
  logic [19:0] live;

  // Two-flop synchronizers; bit 2 holds the previous synchronized level for edge detect.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q <= 3'b111;
      clear_sync_q <= 3'b111;
    end else begin
      start_sync_q <= {start_sync_q[1:0], key_start_n};
      clear_sync_q <= {clear_sync_q[1:0], key_clear_n};
    end
  end

  // A press event is the synchronized level falling from 1 to 0.
  assign start_ev = start_sync_q[2] & ~start_sync_q[1];
  assign clear_ev = clear_sync_q[2] & ~clear_sync_q[1];

  // State register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; in RUN, start beats clear, elsewhere clear beats start.
  always_comb begin
    state_d  = state_q;
    do_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_ev) begin
          do_clear = 1'b1;
        end else if (start_ev) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (start_ev) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (clear_ev) begin
          do_clear = 1'b1;
          state_d  = StIdle;
        end else if (start_ev) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ticks count on the current state only, so the leaving-RUN cycle still counts.
  assign count_en = tick && (state_q == StRun);
  assign at_max   = (min_tens_q == 4'd5) && (min_ones_q == 4'd9) && (sec_tens_q == 4'd5) &&
                    (sec_ones_q == 4'd9) && (tenths_q == 4'd9);

  // BCD cascade increment with wrap or saturate at 59:59.9.
  always_comb begin
    tenths_d   = tenths_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    // Wrap mode gives a one-cycle pulse; saturate mode keeps the flag sticky.
    overflow_d = (WRAP != 0) ? 1'b0 : overflow_q;
    if (do_clear) begin
      tenths_d   = 4'd0;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
      overflow_d = 1'b0;
    end else if (count_en) begin
      if (at_max) begin
        if (WRAP != 0) begin
          tenths_d   = 4'd0;
          sec_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          min_ones_d = 4'd0;
          min_tens_d = 4'd0;
        end
        overflow_d = 1'b1;
      end else if (tenths_q != 4'd9) begin
        tenths_d = tenths_q + 4'd1;
      end else begin
        tenths_d = 4'd0;
        if (sec_ones_q != 4'd9) begin
          sec_ones_d = sec_ones_q + 4'd1;
        end else begin
          sec_ones_d = 4'd0;
          if (sec_tens_q != 4'd5) begin
            sec_tens_d = sec_tens_q + 4'd1;
          end else begin
            sec_tens_d = 4'd0;
            if (min_ones_q != 4'd9) begin
              min_ones_d = min_ones_q + 4'd1;
            end else begin
              min_ones_d = 4'd0;
              min_tens_d = min_tens_q + 4'd1;
            end
          end
        end
      end
    end
  end

  // Digit and overflow registers.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tenths_q   <= 4'd0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      tenths_q   <= tenths_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      overflow_q <= overflow_d;
    end
  end

  assign live     = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q, tenths_q};
  assign running  = (state_q == StRun);
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic [2:0]  lap_sync_q;
  logic        lap_ev;
  logic        lap_hold_q, lap_hold_d;
  logic [19:0] snap_q, snap_d;

  // Lap key synchronizer, same structure as the other keys.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lap_sync_q <= 3'b111;
    end else begin
      lap_sync_q <= {lap_sync_q[1:0], key_lap_n};
    end
  end

  assign lap_ev = lap_sync_q[2] & ~lap_sync_q[1];

  // Lap toggles in RUN (snapshot on freeze), releases in PAUSE, is ignored in IDLE.
  always_comb begin
    lap_hold_d = lap_hold_q;
    snap_d     = snap_q;
    if (do_clear) begin
      lap_hold_d = 1'b0;
    end else if (lap_ev) begin
      unique case (state_q)
        StRun: begin
          lap_hold_d = ~lap_hold_q;
          if (!lap_hold_q) begin
            snap_d = live;
          end
        end
        StPause: lap_hold_d = 1'b0;
        default: lap_hold_d = lap_hold_q;
      endcase
    end
  end

  // Lap hold flag and frozen digit snapshot.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lap_hold_q <= 1'b0;
      snap_q     <= 20'd0;
    end else begin
      lap_hold_q <= lap_hold_d;
      snap_q     <= snap_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones, tenths} = lap_hold_q ? snap_q : live;
  assign lap_hold = lap_hold_q;
`else
  logic unused_lap;
  assign unused_lap = key_lap_n;

  assign {min_tens, min_ones, sec_tens, sec_ones, tenths} = live;
  assign lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: one wrapping and one saturating instance share all inputs.
// Expected {running, lap_hold, overflow, MM:SS.t} words are queued when stimulus is
// issued and compared once the stimulus has completed.
`timescale 1ns/1ps
module tb_stopwatch_bcd;

  logic clkin = 1'b0;
  logic rst_n, tick, key_start_n, key_clear_n, key_lap_n;

  logic [3:0] tenths_w, sec_ones_w, sec_tens_w, min_ones_w, min_tens_w;
  logic [3:0] tenths_s, sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  logic       running_w, lap_hold_w, overflow_w;
  logic       running_s, lap_hold_s, overflow_s;
  logic [22:0] obs_w, obs_s;

  stopwatch_bcd #(.WRAP(1)) dut_w (
    .clkin(clkin), .rst_n(rst_n), .tick(tick),
    .key_start_n(key_start_n), .key_clear_n(key_clear_n), .key_lap_n(key_lap_n),
    .tenths(tenths_w), .sec_ones(sec_ones_w), .sec_tens(sec_tens_w),
    .min_ones(min_ones_w), .min_tens(min_tens_w),
    .running(running_w), .lap_hold(lap_hold_w), .overflow(overflow_w)
  );

  stopwatch_bcd #(.WRAP(0)) dut_s (
    .clkin(clkin), .rst_n(rst_n), .tick(tick),
    .key_start_n(key_start_n), .key_clear_n(key_clear_n), .key_lap_n(key_lap_n),
    .tenths(tenths_s), .sec_ones(sec_ones_s), .sec_tens(sec_tens_s),
    .min_ones(min_ones_s), .min_tens(min_tens_s),
    .running(running_s), .lap_hold(lap_hold_s), .overflow(overflow_s)
  );

  assign obs_w = {running_w, lap_hold_w, overflow_w,
                  min_tens_w, min_ones_w, sec_tens_w, sec_ones_w, tenths_w};
  assign obs_s = {running_s, lap_hold_s, overflow_s,
                  min_tens_s, min_ones_s, sec_tens_s, sec_ones_s, tenths_s};

  always #5 clkin = ~clkin;

  typedef struct {
    string       name;
    logic [22:0] exp;
    bit          sat;
  } sb_t;

  localparam int OpStart = 0;
  localparam int OpClear = 1;
  localparam int OpBoth  = 2;
  localparam int OpTicks = 3;

  typedef struct {
    string       name;
    int          op;
    int          n;
    logic [22:0] exp;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[18];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [19:0] bcd(input int mt, input int mo, input int st, input int so,
                                      input int t);
    return {mt[3:0], mo[3:0], st[3:0], so[3:0], t[3:0]};
  endfunction

  function automatic logic [22:0] pk(input logic run, input logic lap, input logic ov,
                                     input logic [19:0] d);
    return {run, lap, ov, d};
  endfunction

  task automatic push(input string name, input logic [22:0] ew, input logic [22:0] es);
    sb_t r;
    r.name = name; r.exp = ew; r.sat = 1'b0; sbq.push_back(r);
    r.sat = 1'b1; r.exp = es; sbq.push_back(r);
  endtask

  task automatic drain();
    sb_t r;
    logic [22:0] got;
    while (sbq.size() > 0) begin
      r   = sbq.pop_front();
      got = r.sat ? obs_s : obs_w;
      total++;
      if (got !== r.exp) begin
        bad++;
        $display("FAIL %s (%s): got run/lap/ovf/digits=%h expected %h",
                 r.name, r.sat ? "sat" : "wrap", got, r.exp);
      end
    end
  endtask

  task automatic check(input string name, input logic [22:0] ew, input logic [22:0] es);
    push(name, ew, es);
    drain();
  endtask

  // Hold the selected keys low across three clock edges, then release.
  task automatic press(input bit s, input bit c, input bit l);
    @(negedge clkin);
    key_start_n = ~s;
    key_clear_n = ~c;
    key_lap_n   = ~l;
    repeat (3) @(negedge clkin);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    key_lap_n   = 1'b1;
    @(negedge clkin);
  endtask

  // Start press with tick held high over exactly the same three edges.
  task automatic press_start_tick();
    @(negedge clkin);
    key_start_n = 1'b0;
    tick        = 1'b1;
    repeat (3) @(negedge clkin);
    key_start_n = 1'b1;
    tick        = 1'b0;
    @(negedge clkin);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkin);
      tick = 1'b1;
    end
    @(negedge clkin);
    tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [22:0] z;
    logic [22:0] e;
    z = pk(1'b0, 1'b0, 1'b0, bcd(0, 0, 0, 0, 0));

    vecs[0]  = '{"start_idle",    OpStart, 0,  pk(1, 0, 0, bcd(0, 0, 0, 0, 0))};
    vecs[1]  = '{"ticks25",       OpTicks, 25, pk(1, 0, 0, bcd(0, 0, 0, 2, 5))};
    vecs[2]  = '{"pause_a",       OpStart, 0,  pk(0, 0, 0, bcd(0, 0, 0, 2, 5))};
    vecs[3]  = '{"clear_pause",   OpClear, 0,  pk(0, 0, 0, bcd(0, 0, 0, 0, 0))};
    vecs[4]  = '{"start_b",       OpStart, 0,  pk(1, 0, 0, bcd(0, 0, 0, 0, 0))};
    vecs[5]  = '{"ticks10",       OpTicks, 10, pk(1, 0, 0, bcd(0, 0, 0, 1, 0))};
    vecs[6]  = '{"pause_b",       OpStart, 0,  pk(0, 0, 0, bcd(0, 0, 0, 1, 0))};
    vecs[7]  = '{"ticks_paused",  OpTicks, 5,  pk(0, 0, 0, bcd(0, 0, 0, 1, 0))};
    vecs[8]  = '{"resume",        OpStart, 0,  pk(1, 0, 0, bcd(0, 0, 0, 1, 0))};
    vecs[9]  = '{"ticks3",        OpTicks, 3,  pk(1, 0, 0, bcd(0, 0, 0, 1, 3))};
    vecs[10] = '{"start_clear",   OpBoth,  0,  pk(0, 0, 0, bcd(0, 0, 0, 1, 3))};
    vecs[11] = '{"clear_after",   OpClear, 0,  pk(0, 0, 0, bcd(0, 0, 0, 0, 0))};
    vecs[12] = '{"clear_idle",    OpClear, 0,  pk(0, 0, 0, bcd(0, 0, 0, 0, 0))};
    vecs[13] = '{"start_c",       OpStart, 0,  pk(1, 0, 0, bcd(0, 0, 0, 0, 0))};
    vecs[14] = '{"ticks7",        OpTicks, 7,  pk(1, 0, 0, bcd(0, 0, 0, 0, 7))};
    vecs[15] = '{"clear_in_run",  OpClear, 0,  pk(1, 0, 0, bcd(0, 0, 0, 0, 7))};
    vecs[16] = '{"pause_c",       OpStart, 0,  pk(0, 0, 0, bcd(0, 0, 0, 0, 7))};
    vecs[17] = '{"clear_c",       OpClear, 0,  pk(0, 0, 0, bcd(0, 0, 0, 0, 0))};

    rst_n       = 1'b1;
    tick        = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    key_lap_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_state", z, z);
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
    @(negedge clkin);
    check("after_release", z, z);

    // Table-driven run / pause / clear sequences.
    for (int i = 0; i < 18; i++) begin
      push(vecs[i].name, vecs[i].exp, vecs[i].exp);
      case (vecs[i].op)
        OpStart: press(1'b1, 1'b0, 1'b0);
        OpClear: press(1'b0, 1'b1, 1'b0);
        OpBoth:  press(1'b1, 1'b1, 1'b0);
        default: run_ticks(vecs[i].n);
      endcase
      drain();
    end

    // Tick during IDLE->RUN is dropped; tick during RUN->PAUSE is counted.
    e = pk(1, 0, 0, bcd(0, 0, 0, 0, 0));
    push("tick_on_start", e, e);
    press_start_tick();
    drain();
    e = pk(0, 0, 0, bcd(0, 0, 0, 0, 3));
    push("tick_on_pause", e, e);
    press_start_tick();
    drain();
    press(1'b0, 1'b1, 1'b0);
    check("clear_d", z, z);

    // Preload to 59:59.9, then cross the boundary.
    press(1'b1, 1'b0, 1'b0);
    e = pk(1, 0, 0, bcd(5, 9, 5, 9, 9));
    push("preload", e, e);
    run_ticks(35999);
    drain();
    @(negedge clkin);
    tick = 1'b1;
    @(negedge clkin);
    tick = 1'b0;
    check("edge_wrap", pk(1, 0, 1, bcd(0, 0, 0, 0, 0)), pk(1, 0, 1, bcd(5, 9, 5, 9, 9)));
    @(negedge clkin);
    check("ovf_after", pk(1, 0, 0, bcd(0, 0, 0, 0, 0)), pk(1, 0, 1, bcd(5, 9, 5, 9, 9)));
    push("ticks_past", pk(1, 0, 0, bcd(0, 0, 0, 0, 5)), pk(1, 0, 1, bcd(5, 9, 5, 9, 9)));
    run_ticks(5);
    drain();
    push("pause_ovf", pk(0, 0, 0, bcd(0, 0, 0, 0, 5)), pk(0, 0, 1, bcd(5, 9, 5, 9, 9)));
    press(1'b1, 1'b0, 1'b0);
    drain();
    push("clear_ovf", z, z);
    press(1'b0, 1'b1, 1'b0);
    drain();

    // Lap freeze, then reach 00:07.3 running for the reset check.
    press(1'b1, 1'b0, 1'b0);
    run_ticks(40);
    e = pk(1, 0, 0, bcd(0, 0, 0, 4, 0));
    check("at_4_0", e, e);
`ifdef STOPWATCH_LAP_EN
    press(1'b0, 1'b0, 1'b1);
    e = pk(1, 1, 0, bcd(0, 0, 0, 4, 0));
    check("lap_freeze", e, e);
    run_ticks(20);
    check("lap_frozen", e, e);
    press(1'b0, 1'b0, 1'b1);
    e = pk(1, 0, 0, bcd(0, 0, 0, 6, 0));
    check("lap_release", e, e);
    press(1'b0, 1'b0, 1'b1);
    run_ticks(5);
    press(1'b1, 1'b0, 1'b0);
    e = pk(0, 1, 0, bcd(0, 0, 0, 6, 0));
    check("lap_paused", e, e);
    press(1'b0, 1'b0, 1'b1);
    e = pk(0, 0, 0, bcd(0, 0, 0, 6, 5));
    check("lap_pause_rel", e, e);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    run_ticks(8);
    e = pk(1, 1, 0, bcd(0, 0, 0, 6, 5));
    check("lap_at_7_3", e, e);
`else
    press(1'b0, 1'b0, 1'b1);
    e = pk(1, 0, 0, bcd(0, 0, 0, 4, 0));
    check("lap_ignored", e, e);
    run_ticks(33);
    e = pk(1, 0, 0, bcd(0, 0, 0, 7, 3));
    check("live_7_3", e, e);
`endif

    // Asynchronous reset mid-count.
    @(negedge clkin);
    #1 rst_n = 1'b0;
    #1 check("async_reset", z, z);
    @(negedge clkin);
    rst_n = 1'b1;
    push("ticks_after_rst", z, z);
    run_ticks(5);
    drain();
`ifdef STOPWATCH_LAP_EN
    push("lap_idle", z, z);
    press(1'b0, 1'b0, 1'b1);
    drain();
`endif
    press(1'b1, 1'b0, 1'b0);
    e = pk(1, 0, 0, bcd(0, 0, 0, 0, 3));
    push("restart", e, e);
    run_ticks(3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
